// File: rtl/writeback_queue.sv
// writeback_queue: serialises ALU and memory write-back results onto the single
// write port of the register bank. Results wait in a small circular FIFO, and
// readers can see pending values through two forwarding lookup ports.
// Optional feature macro: WRITEBACK_QUEUE_BYPASS_EN. When it is defined, the
// lookup comparators are built. When it is undefined, the lookups always miss.
//
// Handshake: a request transfers on a rising edge where its valid and its ready
// are both high. Each ready is computed without reference to its own valid, so
// a producer may hold valid high until it sees ready. alu_ready depends on
// mem_valid, because the memory entry is always enqueued ahead of the ALU entry.
module writeback_queue #(
  parameter int n     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_address,
  input  logic [n-1:0]               mem_data,
  output logic                       mem_ready,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_address,
  input  logic [n-1:0]               alu_data,
  output logic                       alu_ready,
  output logic                       write,
  output logic [4:0]                 write_address,
  output logic [n-1:0]               write_data,
  input  logic [4:0]                 lookup_address_1,
  input  logic [4:0]                 lookup_address_2,
  output logic                       lookup_hit_1,
  output logic                       lookup_hit_2,
  output logic [n-1:0]               lookup_data_1,
  output logic [n-1:0]               lookup_data_2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [n-1:0]  data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occ;
  logic          pop;
  logic          mem_push;
  logic          alu_push;
  logic [CW:0]   free;
  logic [CW:0]   alu_need;

  assign count = occ;

  // Pop and ready decisions. Free slots count the head that leaves on this edge.
  always_comb begin
    pop       = (occ != '0) && !reset;
    free      = (CW+1)'(DEPTH) - {1'b0, occ} + (CW+1)'(occ != '0);
    alu_need  = mem_valid ? (CW+1)'(2) : (CW+1)'(1);
    mem_ready = !reset && (free >= (CW+1)'(1));
    alu_ready = !reset && (free >= alu_need);
    mem_push  = mem_valid && mem_ready;
    alu_push  = alu_valid && alu_ready;
  end

  // The bank port is driven straight from the head entry. It is held at zero when the queue is idle.
  always_comb begin
    write         = pop;
    write_address = pop ? addr_mem[head] : '0;
    write_data    = pop ? data_mem[head] : '0;
  end

  // Pointers and occupancy. Reset discards every pending entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (pop) head <= head + 1'b1;
      tail <= tail + PW'(mem_push) + PW'(alu_push);
      occ  <= occ + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // Entry storage. The memory result takes the older slot when both paths push on the same edge.
  always_ff @(posedge clock) begin
    if (mem_push) begin
      addr_mem[tail] <= mem_address;
      data_mem[tail] <= mem_data;
    end
    if (alu_push) begin
      addr_mem[tail + PW'(mem_push)] <= alu_address;
      data_mem[tail + PW'(mem_push)] <= alu_data;
    end
  end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  logic [PW-1:0] idx;

  // Forwarding search runs from oldest to youngest, so the youngest match overwrites older ones.
  always_comb begin
    lookup_hit_1  = 1'b0;
    lookup_hit_2  = 1'b0;
    lookup_data_1 = '0;
    lookup_data_2 = '0;
    idx           = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!reset && (CW'(i) < occ)) begin
        if (addr_mem[idx] == lookup_address_1) begin
          lookup_hit_1  = 1'b1;
          lookup_data_1 = data_mem[idx];
        end
        if (addr_mem[idx] == lookup_address_2) begin
          lookup_hit_2  = 1'b1;
          lookup_data_2 = data_mem[idx];
        end
      end
    end
  end
`else
  logic unused_lookup;

  // Forwarding is not built in this configuration, so the lookups always report a miss.
  always_comb begin
    unused_lookup = ^{lookup_address_1, lookup_address_2};
    lookup_hit_1  = 1'b0;
    lookup_hit_2  = 1'b0;
    lookup_data_1 = '0;
    lookup_data_2 = '0;
  end
`endif

endmodule
